mdma_264bx512_ram_resp: RTL and testbench



---
 rtl/mdma_264bx512_ram_resp.sv | 127 ++++++++++++
 tb/tb_mdma_264bx512_ram_resp.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdma_264bx512_ram_resp.sv
// ============================================================================
// mdma_264bx512_ram_resp : 264b x 512 DMA RAM responder with stored parity,
//                          2-cycle read pipeline, error injection and counters
// Rev 1.0
// ============================================================================
`default_nettype none

module mdma_264bx512_ram_resp #(
    parameter int AW = 9,
    parameter int DW = 264,
    parameter int PW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] wadr,
    input  logic          wen,
    input  logic [PW-1:0] wpar,
    input  logic [DW-1:0] wdat,
    input  logic          ren,
    input  logic [AW-1:0] radr,
    output logic [PW-1:0] rpar,
    output logic [DW-1:0] rdat,
    output logic          rsbe,
    output logic          rdbe,
    output logic          rd_vld,
    input  logic          inj_sbe,
    input  logic          inj_dbe,
    input  logic          cnt_clr,
    output logic [CW-1:0] sbe_cnt,
    output logic [CW-1:0] dbe_cnt
);

    localparam int GW    = DW / PW;
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] r_mem  [DEPTH];
    logic [PW-1:0] r_pmem [DEPTH];

    logic [DW-1:0] w_flip;
    logic [DW-1:0] r_s1_dat;
    logic [PW-1:0] r_s1_par;
    logic          r_s1_vld;
    logic [PW-1:0] w_mm;
    logic [PW-1:0] w_mm_m1;
    logic          w_one;
    logic          w_multi;

    // Double injection flips bit 0 and the first bit of group 1
    always_comb begin
        w_flip = '0;
        if (inj_dbe) begin
            w_flip[0]  = 1'b1;
            w_flip[GW] = 1'b1;
        end else if (inj_sbe) begin
            w_flip[0] = 1'b1;
        end
    end

    // Storage and stage-1 data are not reset; non-blocking gives read-first on collision
    always_ff @(posedge clk) begin
        if (wen) begin
            r_mem[wadr]  <= wdat ^ w_flip;
            r_pmem[wadr] <= wpar;
        end
        if (ren) begin
            r_s1_dat <= r_mem[radr];
            r_s1_par <= r_pmem[radr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= ren;
        end
    end

    for (genvar g = 0; g < PW; g++) begin : g_grp
        assign w_mm[g] = (^r_s1_dat[g*GW +: GW]) ^ r_s1_par[g];
    end

    // More than one set bit iff clearing the lowest set bit leaves something
    assign w_mm_m1 = w_mm - {{(PW-1){1'b0}}, 1'b1};
    assign w_multi = |(w_mm & w_mm_m1);
    assign w_one   = (|w_mm) & ~w_multi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= 1'b0;
            rsbe   <= 1'b0;
            rdbe   <= 1'b0;
            rdat   <= '0;
            rpar   <= '0;
        end else begin
            rd_vld <= r_s1_vld;
            rsbe   <= r_s1_vld & w_one;
            rdbe   <= r_s1_vld & w_multi;
            if (r_s1_vld) begin
                rdat <= r_s1_dat;
                rpar <= r_s1_par;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbe_cnt <= '0;
            dbe_cnt <= '0;
        end else begin
            if (cnt_clr) begin
                sbe_cnt <= '0;
            end else if (rd_vld && rsbe && (sbe_cnt != {CW{1'b1}})) begin
                sbe_cnt <= sbe_cnt + CW'(1);
            end
            if (cnt_clr) begin
                dbe_cnt <= '0;
            end else if (rd_vld && rdbe && (dbe_cnt != {CW{1'b1}})) begin
                dbe_cnt <= dbe_cnt + CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mdma_264bx512_ram_resp.sv
// ============================================================================
// tb_mdma_264bx512_ram_resp : randomized bench with queue-based reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mdma_264bx512_ram_resp;

    localparam int AW = 9;
    localparam int DW = 264;
    localparam int PW = 8;
    localparam int CW = 16;
    localparam int GW = 33;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] wadr = '0;
    logic          wen = 1'b0;
    logic [PW-1:0] wpar = '0;
    logic [DW-1:0] wdat = '0;
    logic          ren = 1'b0;
    logic [AW-1:0] radr = '0;
    logic [PW-1:0] rpar;
    logic [DW-1:0] rdat;
    logic          rsbe;
    logic          rdbe;
    logic          rd_vld;
    logic          inj_sbe = 1'b0;
    logic          inj_dbe = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] sbe_cnt;
    logic [CW-1:0] dbe_cnt;

    always #5 clk = ~clk;

    mdma_264bx512_ram_resp #(.AW(AW), .DW(DW), .PW(PW), .CW(CW)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wadr    (wadr),
        .wen     (wen),
        .wpar    (wpar),
        .wdat    (wdat),
        .ren     (ren),
        .radr    (radr),
        .rpar    (rpar),
        .rdat    (rdat),
        .rsbe    (rsbe),
        .rdbe    (rdbe),
        .rd_vld  (rd_vld),
        .inj_sbe (inj_sbe),
        .inj_dbe (inj_dbe),
        .cnt_clr (cnt_clr),
        .sbe_cnt (sbe_cnt),
        .dbe_cnt (dbe_cnt)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] d;
        logic [PW-1:0] p;
    } rd_t;

    rd_t           exp_q[$];
    logic [DW-1:0] mdl_mem [512];
    logic [PW-1:0] mdl_par [512];
    int            cyc;
    int            n_checks;
    int            n_pass;
    logic          e_vld, e_sbe, e_dbe;
    logic [DW-1:0] e_rdat;
    logic [PW-1:0] e_rpar;
    logic [CW-1:0] e_scnt, e_dcnt;
    logic [DW-1:0] pattern;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] calc_par(input logic [DW-1:0] d);
        logic [PW-1:0] r;
        for (int g = 0; g < PW; g++) r[g] = ^d[g*GW +: GW];
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        logic [287:0] t;
        for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
        return t[DW-1:0];
    endfunction

    task automatic idle();
        wen = 1'b0; ren = 1'b0; inj_sbe = 1'b0; inj_dbe = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic check_outputs();
        check("rd_vld",  DW'(rd_vld),  DW'(e_vld));
        check("rsbe",    DW'(rsbe),    DW'(e_sbe));
        check("rdbe",    DW'(rdbe),    DW'(e_dbe));
        check("rdat",    rdat,         e_rdat);
        check("rpar",    DW'(rpar),    DW'(e_rpar));
        check("sbe_cnt", DW'(sbe_cnt), DW'(e_scnt));
        check("dbe_cnt", DW'(dbe_cnt), DW'(e_dcnt));
    endtask

    // One clock: model sees the driven inputs, the edge happens, outputs are compared
    task automatic tick();
        rd_t           t;
        logic [DW-1:0] m;
        logic          clr;
        int            nmm;
        if (ren) begin
            t.due = cyc + 2;
            t.d   = mdl_mem[radr];
            t.p   = mdl_par[radr];
            exp_q.push_back(t);
        end
        if (wen) begin
            m = '0;
            if (inj_dbe) begin
                m[0] = 1'b1; m[GW] = 1'b1;
            end else if (inj_sbe) begin
                m[0] = 1'b1;
            end
            mdl_mem[wadr] = wdat ^ m;
            mdl_par[wadr] = wpar;
        end
        clr = cnt_clr;
        @(posedge clk);
        cyc++;
        #1;
        if (clr) e_scnt = '0;
        else if (e_vld && e_sbe && e_scnt != 16'hFFFF) e_scnt = e_scnt + 16'd1;
        if (clr) e_dcnt = '0;
        else if (e_vld && e_dbe && e_dcnt != 16'hFFFF) e_dcnt = e_dcnt + 16'd1;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            t      = exp_q.pop_front();
            e_vld  = 1'b1;
            e_rdat = t.d;
            e_rpar = t.p;
            nmm    = $countones(calc_par(t.d) ^ t.p);
            e_sbe  = (nmm == 1);
            e_dbe  = (nmm >= 2);
        end else begin
            e_vld = 1'b0; e_sbe = 1'b0; e_dbe = 1'b0;
        end
        check_outputs();
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        exp_q.delete();
        e_vld = 1'b0; e_sbe = 1'b0; e_dbe = 1'b0;
        e_rdat = '0; e_rpar = '0; e_scnt = '0; e_dcnt = '0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        check_outputs();
        rst_n = 1'b1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [PW-1:0] pflip, input logic s, input logic dd);
        wen = 1'b1; wadr = a; wdat = d; wpar = calc_par(d) ^ pflip;
        inj_sbe = s; inj_dbe = dd;
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_pass = 0;
        do_reset();

        // Basic write then read at 0x005
        pattern = {33{8'h01}};
        write_word(9'h005, pattern, 8'h00, 1'b0, 1'b0); tick();
        ren = 1'b1; radr = 9'h005; tick();
        tick(); tick();
        check("basic_rdat", rdat, pattern);

        // Full fill then streaming reads of every address
        for (int i = 0; i < 512; i++) begin
            write_word(9'(i), (i == 5) ? pattern : rnd_word(), 8'h00, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 512; i++) begin
            ren = 1'b1; radr = 9'(i); tick();
        end
        tick(); tick();

        // Same-cycle write/read collision at 0x1FF
        write_word(9'h1FF, rnd_word(), 8'h00, 1'b0, 1'b0);
        ren = 1'b1; radr = 9'h1FF; tick();
        ren = 1'b1; radr = 9'h1FF; tick();
        tick(); tick();

        // Single and double error injection
        write_word(9'h010, rnd_word(), 8'h00, 1'b1, 1'b0); tick();
        ren = 1'b1; radr = 9'h010; tick();
        repeat (3) tick();
        check("sbe_cnt_one", DW'(sbe_cnt), DW'(16'd1));
        write_word(9'h011, rnd_word(), 8'h00, 1'b0, 1'b1); tick();
        ren = 1'b1; radr = 9'h011; tick();
        repeat (3) tick();
        check("dbe_cnt_one", DW'(dbe_cnt), DW'(16'd1));

        // Parity bits 2 and 5 corrupted at write time
        write_word(9'h012, rnd_word(), 8'h24, 1'b0, 1'b0); tick();
        ren = 1'b1; radr = 9'h012; tick();
        tick(); tick();
        tick();

        // Saturate sbe_cnt, then clear while rsbe is active
        write_word(9'h020, rnd_word(), 8'h00, 1'b1, 1'b0); tick();
        for (int i = 0; i < 65540; i++) begin
            ren = 1'b1; radr = 9'h020; tick();
        end
        check("sbe_sat", DW'(sbe_cnt), DW'(16'hFFFF));
        ren = 1'b1; radr = 9'h020; cnt_clr = 1'b1; tick();
        check("sbe_clr", DW'(sbe_cnt), DW'(16'd0));
        repeat (3) tick();

        // Randomized traffic; writes kept away from 0x005 so it survives for later
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                write_word(9'($urandom_range(256, 510)), rnd_word(),
                           ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00,
                           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
            end
            if ($urandom_range(0, 3) != 0) begin
                ren = 1'b1; radr = 9'($urandom_range(0, 511));
            end
            cnt_clr = ($urandom_range(0, 19) == 0);
            tick();
        end
        tick(); tick();

        // Reset one cycle after a read: the read must vanish, data must persist
        ren = 1'b1; radr = 9'h005; tick();
        tick();
        do_reset();
        repeat (3) tick();
        ren = 1'b1; radr = 9'h005; tick();
        tick(); tick();
        check("persist_rdat", rdat, pattern);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
